// File: rtl/mem_pkg.sv
// Shared definitions for the cleared RAM: FSM state encoding and byte-lane sizing.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int MEM_DATA_WIDTH = 16;
    localparam int STRB_WIDTH     = MEM_DATA_WIDTH / 8;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Plain single-port synchronous RAM: per-lane write enables, registered read.
module ram_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read data only moves on a read, so it holds while a response is stalled.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < DATA_WIDTH/8; i++) begin
                    if (i_wstrb[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cleared_ram.sv
// Single-port RAM with valid/ready request, held read response and a hardware clear walk.
module cleared_ram
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    output logic                    busy,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata
);

    localparam int STRB_W = strb_width(DATA_WIDTH);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_busy;
    logic                  r_rsp_valid;
    logic                  r_rsp_zero;

    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_rsp_fire;
    logic                  w_ram_en;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [STRB_W-1:0]     w_ram_wstrb;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_in_range = int'(req_addr) < DEPTH;
    assign req_ready  = (r_state == ST_IDLE) && !clear && (!r_rsp_valid || rsp_ready);
    assign w_accept   = req_valid && req_ready;
    assign w_rsp_fire = r_rsp_valid && rsp_ready;

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = req_addr;
        w_ram_wdata = req_wdata;
        w_ram_wstrb = req_wstrb;
        if (r_state == ST_CLEAR) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_addr  = r_clr_addr;
            w_ram_wdata = '0;
            w_ram_wstrb = '1;
        end else begin
            // Out-of-range requests never reach the array.
            w_ram_en = w_accept && w_in_range;
            w_ram_we = req_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_CLEAR;
            r_clr_addr  <= '0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_zero  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
                    if (r_clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_busy  <= 1'b1;
                end
            endcase

            // Response register runs independently of the clear walk.
            if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_accept && !req_write) begin
                r_rsp_valid <= 1'b1;
                r_rsp_zero  <= !w_in_range;
            end
        end
    end

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .i_wstrb (w_ram_wstrb),
        .o_rdata (w_ram_rdata)
    );

    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_zero ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_cleared_ram.sv
// Scoreboard bench for cleared_ram: DUT 0 full depth (256), DUT 1 partial depth (200).
module tb_cleared_ram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clr   [2];
    logic        busy  [2];
    logic        rv    [2];
    logic        rqr   [2];
    logic        rw    [2];
    logic [7:0]  ra    [2];
    logic [15:0] wd    [2];
    logic [1:0]  ws    [2];
    logic        vld   [2];
    logic        rr    [2];
    logic [15:0] rd    [2];

    logic [15:0] exp_q [2][$];
    logic        hold_pend [2];
    logic [15:0] hold_data [2];

    int n_checks = 0;
    int n_errors = 0;

    cleared_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256)) u_dut0 (
        .clk(clk), .reset(reset), .clear(clr[0]), .busy(busy[0]),
        .req_valid(rv[0]), .req_ready(rqr[0]), .req_write(rw[0]), .req_addr(ra[0]),
        .req_wdata(wd[0]), .req_wstrb(ws[0]),
        .rsp_valid(vld[0]), .rsp_ready(rr[0]), .rsp_rdata(rd[0])
    );

    cleared_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clr[1]), .busy(busy[1]),
        .req_valid(rv[1]), .req_ready(rqr[1]), .req_write(rw[1]), .req_addr(ra[1]),
        .req_wdata(wd[1]), .req_wstrb(ws[1]),
        .rsp_valid(vld[1]), .rsp_ready(rr[1]), .rsp_rdata(rd[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Monitor: pops one expectation per consumed response, checks hold stability.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (hold_pend[d]) begin
                chk($sformatf("hold_valid%0d", d), 32'(vld[d]), 32'd1);
                chk($sformatf("hold_data%0d", d), 32'(rd[d]), 32'(hold_data[d]));
            end
            hold_pend[d] = (vld[d] === 1'b1) && (rr[d] === 1'b0);
            hold_data[d] = rd[d];
            if (vld[d] === 1'b1 && rr[d] === 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp%0d actual=%h required=none", d, rd[d]);
                end else begin
                    chk($sformatf("rsp_data%0d", d), 32'(rd[d]), 32'(exp_q[d].pop_front()));
                end
            end
        end
    end

    task automatic do_req(input int d, input bit w, input logic [7:0] a,
                          input logic [15:0] data, input logic [1:0] s, input logic [15:0] exp);
        bit ok = 0;
        rv[d] = 1'b1; rw[d] = w; ra[d] = a; wd[d] = data; ws[d] = s;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (rqr[d] === 1'b1) ok = 1;
        end
        if (!ok) begin
            bound_fail($sformatf("req_accept%0d", d));
        end else begin
            @(posedge clk); #1;
            if (!w) exp_q[d].push_back(exp);
        end
        rv[d] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (exp_q[0].size() + exp_q[1].size()) != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    endtask

    // Counts busy cycles per DUT over a fixed window; req_ready must stay low while busy.
    task automatic count_busy(input int cycles, output int c0, output int c1);
        c0 = 0; c1 = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy[0] === 1'b1) begin c0++; chk("ready_low_busy0", 32'(rqr[0]), 32'd0); end
            if (busy[1] === 1'b1) begin c1++; chk("ready_low_busy1", 32'(rqr[1]), 32'd0); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            clr[d] = 0; rv[d] = 0; rw[d] = 0; ra[d] = 0; wd[d] = 0; ws[d] = 0; rr[d] = 1;
            hold_pend[d] = 0; hold_data[d] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", 32'(busy[d]), 32'd1);
            chk("reset_rsp_valid", 32'(vld[d]), 32'd0);
            chk("reset_rsp_rdata", 32'(rd[d]), 32'd0);
            chk("reset_req_ready", 32'(rqr[d]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // Clear walk after reset release
        count_busy(300, c0, c1);
        chk("reset_walk_len0", 32'(c0), 32'd256);
        chk("reset_walk_len1", 32'(c1), 32'd200);
        chk("idle_ready0", 32'(rqr[0]), 32'd1);
        @(posedge clk); #1;
        do_req(0, 0, 8'h7F, 16'h0, 2'b00, 16'h0000);
        drain();

        // Strobed writes, write-then-read
        do_req(0, 1, 8'd5, 16'hBEEF, 2'b11, 16'h0);
        do_req(0, 0, 8'd5, 16'h0,    2'b00, 16'hBEEF);
        do_req(0, 1, 8'd5, 16'h1234, 2'b01, 16'h0);
        do_req(0, 0, 8'd5, 16'h0,    2'b00, 16'hBE34);
        do_req(0, 1, 8'd5, 16'hFFFF, 2'b00, 16'h0);
        do_req(0, 0, 8'd5, 16'h0,    2'b00, 16'hBE34);
        do_req(0, 1, 8'd5, 16'hAB00, 2'b10, 16'h0);
        do_req(0, 0, 8'd5, 16'h0,    2'b00, 16'hAB34);
        drain();

        // Backpressure: reads 1,2,3 with rsp_ready low after the first
        do_req(0, 1, 8'd1, 16'h1111, 2'b11, 16'h0);
        do_req(0, 1, 8'd2, 16'h2222, 2'b11, 16'h0);
        do_req(0, 1, 8'd3, 16'h3333, 2'b11, 16'h0);
        rr[0] = 1'b0;
        do_req(0, 0, 8'd1, 16'h0, 2'b00, 16'h1111);
        fork
            do_req(0, 0, 8'd2, 16'h0, 2'b00, 16'h2222);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("ready_low_bp", 32'(rqr[0]), 32'd0);
                end
                @(posedge clk); #1;
                rr[0] = 1'b1;
            end
        join
        do_req(0, 0, 8'd3, 16'h0, 2'b00, 16'h3333);
        drain();

        // Clear with a pending response; a second clear mid-walk is ignored
        for (int a = 0; a < 4; a++) do_req(0, 1, 8'(a), 16'hA0A0 + 16'(a) * 16'h0101, 2'b11, 16'h0);
        rr[0] = 1'b0;
        do_req(0, 0, 8'd2, 16'h0, 2'b00, 16'hA2A2);
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        c0 = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy[0] === 1'b1) begin c0++; chk("ready_low_clear", 32'(rqr[0]), 32'd0); end
            @(posedge clk); #1;
            if (i == 10) rr[0] = 1'b1;
            if (i == 20) clr[0] = 1'b1;
            if (i == 21) clr[0] = 1'b0;
        end
        chk("clear_walk_len", 32'(c0), 32'd256);
        for (int a = 0; a < 4; a++) do_req(0, 0, 8'(a), 16'h0, 2'b00, 16'h0000);
        drain();

        // Partial depth: out-of-range write ignored, read returns 0
        do_req(1, 1, 8'd50,  16'h5555, 2'b11, 16'h0);
        do_req(1, 1, 8'd199, 16'h7777, 2'b11, 16'h0);
        do_req(1, 1, 8'd250, 16'hFFFF, 2'b11, 16'h0);
        do_req(1, 0, 8'd250, 16'h0, 2'b00, 16'h0000);
        do_req(1, 0, 8'd50,  16'h0, 2'b00, 16'h5555);
        do_req(1, 0, 8'd199, 16'h0, 2'b00, 16'h7777);
        drain();

        // Reset 100 cycles into a clear walk restarts it from address 0
        do_req(0, 1, 8'd200, 16'h1357, 2'b11, 16'h0);
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        count_busy(300, c0, c1);
        chk("reset_mid_walk_len0", 32'(c0), 32'd256);
        chk("reset_mid_walk_len1", 32'(c1), 32'd200);
        @(posedge clk); #1;
        do_req(0, 0, 8'd200, 16'h0, 2'b00, 16'h0000);
        do_req(1, 0, 8'd50,  16'h0, 2'b00, 16'h0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
